// File: rtl/rom_reader_pkg.sv
// Shared types and sizing helpers for the ROM reader.
package rom_reader_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    // Timeout counter must hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rom_reader_if.sv
// Command, ROM request and byte-stream signals of the ROM reader.
interface rom_reader_if
    import rom_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              i_start;
    logic [ADDR_W-1:0] i_base;
    logic [ADDR_W:0]   i_len;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic              o_rom_read;
    logic [ADDR_W-1:0] o_rom_address;
    logic [DATA_W-1:0] i_rom_data;
    logic              i_rom_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;

    modport master (
        input  i_start, i_base, i_len, i_rom_data, i_rom_valid, i_ready,
        output o_busy, o_done, o_error, o_rom_read, o_rom_address, o_data, o_valid
    );

    modport slave (
        output i_start, i_base, i_len, i_rom_data, i_rom_valid, i_ready,
        input  o_busy, o_done, o_error, o_rom_read, o_rom_address, o_data, o_valid
    );

endinterface

// File: rtl/rom_reader.sv
// Walks a block of ROM bytes: one read request per byte, each byte handed
// off on a valid/ready stream, with a per-request response timeout.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rom_reader_if.master bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              busy_q, done_q, error_q, read_q, valid_q;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    addr_d  = bus.i_base;
                    rem_d   = bus.i_len;
                    state_d = (bus.i_len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response on the timeout cycle still wins over the error.
                if (bus.i_rom_valid) begin
                    data_d  = bus.i_rom_data;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_OUT: begin
                if (bus.i_ready) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_d == '0) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERR);
            read_q  <= (state_d == S_REQ);
            valid_q <= (state_d == S_OUT);
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_error       = error_q;
    assign bus.o_rom_read    = read_q;
    assign bus.o_rom_address = addr_q;
    assign bus.o_data        = data_q;
    assign bus.o_valid       = valid_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a one-cycle-latency ROM (mem[a] = a ^ 8'hA5).
module tb_rom_reader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_reader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ROM model; rom_dead turns it into a stub that never answers.
    logic          rom_dead  = 1'b0;
    logic          rom_valid = 1'b0;
    logic [DW-1:0] rom_data  = '0;
    always @(posedge clk) begin
        rom_valid <= 1'b0;
        if (bus.o_rom_read && !rom_dead) begin
            rom_valid <= 1'b1;
            rom_data  <= bus.o_rom_address ^ 8'hA5;
        end
    end
    assign bus.i_rom_valid = rom_valid;
    assign bus.i_rom_data  = rom_data;

    // Monitor on the falling edge; histories only grow, tests use deltas.
    int            cyc = 0;
    logic [AW-1:0] rd_addr[$];
    int            rd_cyc[$];
    logic [DW-1:0] bytes_q[$];
    int            hs_cyc = 0, done_cyc = 0, err_cyc = 0;
    int            done_n = 0, err_n = 0, busy_n = 0, valid_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_rom_read) begin
                rd_addr.push_back(bus.o_rom_address);
                rd_cyc.push_back(cyc);
            end
            if (bus.o_valid) valid_n++;
            if (bus.o_valid && bus.i_ready) begin
                bytes_q.push_back(bus.o_data);
                hs_cyc = cyc;
            end
            if (bus.o_done)  begin done_n++; done_cyc = cyc; end
            if (bus.o_error) begin err_n++;  err_cyc  = cyc; end
            if (bus.o_busy)  busy_n++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] len, output int scyc);
        bus.i_start = 1'b1;
        bus.i_base  = base;
        bus.i_len   = len;
        scyc        = cyc;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit to);
        int d0;
        d0 = done_n + err_n;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_n + err_n != d0) begin
                to = 1'b0;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++;
        if ({bus.o_busy, bus.o_done, bus.o_error, bus.o_rom_read, bus.o_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 00000",
                     {bus.o_busy, bus.o_done, bus.o_error, bus.o_rom_read, bus.o_valid});
        end
        n_checks++;
        if (bus.o_rom_address !== 8'h00) begin
            n_fail++; $display("FAIL reset_addr: got %h exp 00", bus.o_rom_address);
        end
        n_checks++;
        if (bus.o_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h exp 00", bus.o_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic run_block(input string nm, input logic [AW-1:0] base,
                             input logic [AW-1:0] exp_a[4], input logic [DW-1:0] exp_d[4]);
        int r0, b0, d0, s;
        bit to;
        logic [7:0] got;
        r0 = rd_addr.size(); b0 = bytes_q.size(); d0 = done_n;
        bus.i_ready = 1'b1;
        start_xfer(base, 9'd4, s);
        wait_end(60, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got no done, exp done", nm); end
        n_checks++;
        if (rd_addr.size() - r0 !== 4) begin
            n_fail++; $display("FAIL %s_reads: got %0d exp 4", nm, rd_addr.size() - r0);
        end
        n_checks++;
        if (bytes_q.size() - b0 !== 4) begin
            n_fail++; $display("FAIL %s_bytes: got %0d exp 4", nm, bytes_q.size() - b0);
        end
        for (int i = 0; i < 4; i++) begin
            got = (r0 + i < rd_addr.size()) ? rd_addr[r0 + i] : 8'h00;
            n_checks++;
            if (got !== exp_a[i]) begin
                n_fail++; $display("FAIL %s_addr[%0d]: got %h exp %h", nm, i, got, exp_a[i]);
            end
            got = (b0 + i < bytes_q.size()) ? bytes_q[b0 + i] : 8'h00;
            n_checks++;
            if (got !== exp_d[i]) begin
                n_fail++; $display("FAIL %s_data[%0d]: got %h exp %h", nm, i, got, exp_d[i]);
            end
        end
        n_checks++;
        if (done_n - d0 !== 1) begin
            n_fail++; $display("FAIL %s_done_count: got %0d exp 1", nm, done_n - d0);
        end
        n_checks++;
        if (done_cyc !== hs_cyc + 1) begin
            n_fail++; $display("FAIL %s_done_latency: got %0d exp %0d", nm, done_cyc - hs_cyc, 1);
        end
        if (rd_addr.size() - r0 == 4) begin
            n_checks++;
            if (rd_cyc[r0 + 3] - rd_cyc[r0] !== 9) begin
                n_fail++; $display("FAIL %s_rate: got %0d exp 9", nm, rd_cyc[r0 + 3] - rd_cyc[r0]);
            end
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_busy: got 1 exp 0", nm); end
    endtask

    task automatic test_basic();
        logic [AW-1:0] a[4];
        logic [DW-1:0] d[4];
        a = '{8'h10, 8'h11, 8'h12, 8'h13};
        d = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        run_block("basic", 8'h10, a, d);
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a[4];
        logic [DW-1:0] d[4];
        a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        d = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
        run_block("wrap", 8'hFE, a, d);
    endtask

    task automatic test_zero_len();
        int r0, bn0, d0, s;
        bit to;
        r0 = rd_addr.size(); bn0 = busy_n; d0 = done_n;
        start_xfer(8'h55, 9'd0, s);
        wait_end(10, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got no done, exp done"); end
        n_checks++;
        if (done_cyc !== s + 1) begin
            n_fail++; $display("FAIL zero_done_latency: got %0d exp 1", done_cyc - s);
        end
        n_checks++;
        if (busy_n - bn0 !== 1) begin
            n_fail++; $display("FAIL zero_busy_cycles: got %0d exp 1", busy_n - bn0);
        end
        n_checks++;
        if (rd_addr.size() - r0 !== 0) begin
            n_fail++; $display("FAIL zero_reads: got %0d exp 0", rd_addr.size() - r0);
        end
        n_checks++;
        if (done_n - d0 !== 1) begin
            n_fail++; $display("FAIL zero_done_count: got %0d exp 1", done_n - d0);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d[3];
        int r0, d0, s, rb, unstable;
        bit seen, to;
        exp_d = '{8'h85, 8'h84, 8'h87};
        r0 = rd_addr.size(); d0 = done_n;
        bus.i_ready = 1'b0;
        start_xfer(8'h20, 9'd3, s);
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.o_valid) begin seen = 1'b1; break; end
                step();
            end
            n_checks++;
            if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got 0 exp 1", k); end
            n_checks++;
            if (bus.o_data !== exp_d[k]) begin
                n_fail++; $display("FAIL bp_data[%0d]: got %h exp %h", k, bus.o_data, exp_d[k]);
            end
            rb = rd_addr.size();
            unstable = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (bus.o_valid !== 1'b1 || bus.o_data !== exp_d[k]) unstable++;
            end
            n_checks++;
            if (unstable !== 0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %0d unstable cycles exp 0", k, unstable);
            end
            n_checks++;
            if (rd_addr.size() !== rb) begin
                n_fail++; $display("FAIL bp_early_read[%0d]: got %0d reads exp 0", k, rd_addr.size() - rb);
            end
            bus.i_ready = 1'b1;
            step();
            bus.i_ready = 1'b0;
        end
        wait_end(20, to);
        n_checks++;
        if (rd_addr.size() - r0 !== 3) begin
            n_fail++; $display("FAIL bp_reads: got %0d exp 3", rd_addr.size() - r0);
        end
        n_checks++;
        if (done_n - d0 !== 1) begin
            n_fail++; $display("FAIL bp_done_count: got %0d exp 1", done_n - d0);
        end
    endtask

    task automatic test_timeout();
        int r0, v0, e0, d0, s, rc;
        bit to;
        r0 = rd_addr.size(); v0 = valid_n; e0 = err_n; d0 = done_n;
        rom_dead = 1'b1;
        bus.i_ready = 1'b1;
        start_xfer(8'h30, 9'd2, s);
        wait_end(40, to);
        rom_dead = 1'b0;
        rc = (rd_addr.size() > r0) ? rd_cyc[r0] : -100;
        n_checks++;
        if (err_n - e0 !== 1) begin
            n_fail++; $display("FAIL to_error_count: got %0d exp 1", err_n - e0);
        end
        n_checks++;
        if (err_cyc - rc !== 9) begin
            n_fail++; $display("FAIL to_error_latency: got %0d exp 9", err_cyc - rc);
        end
        n_checks++;
        if (valid_n - v0 !== 0) begin
            n_fail++; $display("FAIL to_valid: got %0d valid cycles exp 0", valid_n - v0);
        end
        n_checks++;
        if (rd_addr.size() - r0 !== 1) begin
            n_fail++; $display("FAIL to_reads: got %0d exp 1", rd_addr.size() - r0);
        end
        n_checks++;
        if (done_n - d0 !== 0 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL to_idle: got done %0d busy %b exp 0 0", done_n - d0, bus.o_busy);
        end
    endtask

    task automatic test_reset_abort();
        int d0, e0, s;
        rom_dead = 1'b1;
        start_xfer(8'h40, 9'd3, s);
        step(); step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.o_busy, bus.o_done, bus.o_error, bus.o_rom_read, bus.o_valid} !== 5'b0 ||
            bus.o_rom_address !== 8'h00 || bus.o_data !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_outputs: got flags %b addr %h data %h exp 00000 00 00",
                     {bus.o_busy, bus.o_done, bus.o_error, bus.o_rom_read, bus.o_valid},
                     bus.o_rom_address, bus.o_data);
        end
        rst = 1'b0;
        rom_dead = 1'b0;
        d0 = done_n; e0 = err_n;
        repeat (12) step();
        n_checks++;
        if (done_n - d0 !== 0 || err_n - e0 !== 0) begin
            n_fail++; $display("FAIL abort_pulses: got done %0d err %0d exp 0 0", done_n - d0, err_n - e0);
        end
    endtask

    task automatic test_len256_ignore();
        int r0, b0, d0, s, s2, bad;
        bit to;
        r0 = rd_addr.size(); b0 = bytes_q.size(); d0 = done_n;
        bus.i_ready = 1'b1;
        start_xfer(8'h00, 9'h100, s);
        repeat (5) step();
        n_checks++;
        if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL long_busy: got 0 exp 1"); end
        start_xfer(8'h80, 9'd1, s2);
        wait_end(1000, to);
        repeat (8) step();
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL long_timeout: got no done, exp done"); end
        n_checks++;
        if (bytes_q.size() - b0 !== 256) begin
            n_fail++; $display("FAIL long_bytes: got %0d exp 256", bytes_q.size() - b0);
        end
        n_checks++;
        if (rd_addr.size() - r0 !== 256) begin
            n_fail++; $display("FAIL long_reads: got %0d exp 256", rd_addr.size() - r0);
        end
        bad = 0;
        for (int i = 0; i < 256 && b0 + i < bytes_q.size(); i++) begin
            if (bytes_q[b0 + i] !== (8'(i) ^ 8'hA5)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL long_data: got %0d wrong bytes exp 0", bad); end
        n_checks++;
        if (done_n - d0 !== 1) begin
            n_fail++; $display("FAIL long_done_count: got %0d exp 1", done_n - d0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running exp finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_start = 1'b0;
        bus.i_base  = '0;
        bus.i_len   = '0;
        bus.i_ready = 1'b0;
        step();
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_timeout();
        test_reset_abort();
        test_len256_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
